jacobi_row_sequencer: RTL and testbench
=======================================

JACOBI_ROW_SEQUENCER -- requirements
Module: jacobi_row_sequencer

Interface
REQ-001 Parameters SHALL be: DIM, default 4, matrix dimension, legal range 2..64; ADDR_W, default 12, Y SRAM address width; IDX_W, default 6, row/column index width; MULT_LAT, default 3, complex-multiplier latency; ADD_LAT, default 2, complex adder/subtractor latency; DIV_LAT, default 6, divider latency.
REQ-002 clock  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a solve.
REQ-005 max_iter  input  8  Jacobi sweep count; sampled when start is accepted.
REQ-006 busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 iter_cnt  output  8  current sweep index, starting at 0.
REQ-009 y_addr  output  ADDR_W  Y SRAM address, equal to row*DIM+col.
REQ-010 v_addr  output  IDX_W  V/x read index, equal to col.
REQ-011 v_bank  output  1  x bank read this sweep; x_wr_bank is its inverse.
REQ-012 mult_valid  output  1  issue strobe to the complex multiplier.
REQ-013 acc_en  output  1  add the product arriving at the multiplier output into the accumulator.
REQ-014 acc_first  output  1  load the product instead of adding it; asserted only together with acc_en.
REQ-015 diag_cap  output  1  latch the product slot as a_ii for the divider.
REQ-016 sub_valid  output  1  launch b_i minus accumulator.
REQ-017 div_valid  output  1  launch the divider.
REQ-018 x_wr_en  output  1  write the divider result.
REQ-019 x_wr_addr  output  IDX_W  write index, equal to the current row.
REQ-020 x_wr_bank  output  1  bank written, always the inverse of v_bank.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, DRAIN, SUB, DIV, WRITE.
REQ-022 In IDLE, start with max_iter>0 SHALL move the FSM to ISSUE with row=0, col=0, iter_cnt=0 and the gap counter at 0.
REQ-023 In IDLE, start with max_iter==0 SHALL pulse done on the next cycle, issue no strobes, and leave busy low.
REQ-024 In ISSUE, a column SHALL be issued every ADD_LAT cycles: mult_valid high for exactly one cycle, with y_addr and v_addr valid in that same cycle.
REQ-025 ISSUE SHALL last exactly DIM*ADD_LAT cycles per row.
REQ-026 The per-issue timing rule SHALL avoid any accumulator read-after-write hazard.
REQ-027 Exactly MULT_LAT cycles after each issue, the sequencer SHALL assert diag_cap if col==row, otherwise acc_en.
REQ-028 acc_first SHALL accompany acc_en for the first non-diagonal column of each row only: col 1 for row 0, col 0 otherwise.
REQ-029 acc_en and diag_cap SHALL never be high in the same cycle.
REQ-030 DRAIN SHALL last MULT_LAT+ADD_LAT cycles after the last issue.
REQ-031 SUB SHALL last ADD_LAT cycles, with sub_valid on its first cycle only.
REQ-032 DIV SHALL last DIV_LAT cycles, with div_valid on its first cycle only.
REQ-033 WRITE SHALL last 1 cycle with x_wr_en=1 and x_wr_addr=row.
REQ-034 The row period SHALL be DIM*ADD_LAT+MULT_LAT+2*ADD_LAT+DIV_LAT+1 cycles, which is 22 at the defaults.
REQ-035 After WRITE with row<DIM-1, the FSM SHALL increment row, clear col, and return to ISSUE.
REQ-036 After WRITE with row==DIM-1 and iter_cnt<max_iter-1, the FSM SHALL clear row, increment iter_cnt, toggle v_bank, and return to ISSUE.
REQ-037 After WRITE with row==DIM-1 and iter_cnt==max_iter-1, the FSM SHALL go to IDLE with a one-cycle done pulse; iter_cnt SHALL hold its final value until the next start.
REQ-038 start while busy SHALL be ignored, with no effect on state or counters.
REQ-039 Only one row SHALL be in flight at a time; the pipelines SHALL be empty at each WRITE.
REQ-040 When no strobe is active, the address outputs SHALL hold their last value.

Reset
REQ-041 reset SHALL take priority over start and over every state transition.
REQ-042 While reset is high: FSM=IDLE, and row, col, gap counter, iter_cnt, v_bank, all addresses and all strobes (busy, done, mult_valid, acc_en, acc_first, diag_cap, sub_valid, div_valid, x_wr_en) SHALL be 0; x_wr_bank SHALL be 1.
REQ-043 Reset mid-solve SHALL abort the solve, with no further strobes and no done pulse.
REQ-044 Delayed strobes already scheduled inside the sequencer SHALL be cancelled by reset.

Verification
REQ-045 Defaults, max_iter=1, start at cycle 0 -> mult_valid at cycles 1,3,5,7 with y_addr 0..3; diag_cap at cycle 4; acc_en at 6,8,10 with acc_first at 6; x_wr_en for row 0 at cycle 22; done after the row-3 WRITE at cycle 88+1.
REQ-046 max_iter=2 -> v_bank changes 0->1 after the first sweep; the second sweep writes bank 0; iter_cnt goes 0->1; one done pulse at the end.
REQ-047 max_iter=0 -> done one cycle after start, no mult_valid, busy never asserted.
REQ-048 start pulsed during row 2 -> counters and strobe timing identical to the run without it.
REQ-049 reset asserted during DIV of row 1 -> the next cycle has all outputs at reset values; a later start restarts from row 0 with correct timing.
REQ-050 Row 2 with DIM=4 -> diag_cap on the 3rd product slot, acc_first on col 0, exactly 3 acc_en pulses, acc_en and diag_cap never overlapping.

Source files
------------

// File: rtl/jacobi_row_sequencer_if.sv
// Control/strobe bundle between the Jacobi row sequencer and its complex datapath.
interface jacobi_row_sequencer_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned IDX_W  = 6
);
    logic              start;
    logic [7:0]        max_iter;
    logic              busy;
    logic              done;
    logic [7:0]        iter_cnt;
    logic [ADDR_W-1:0] y_addr;
    logic [IDX_W-1:0]  v_addr;
    logic              v_bank;
    logic              mult_valid;
    logic              acc_en;
    logic              acc_first;
    logic              diag_cap;
    logic              sub_valid;
    logic              div_valid;
    logic              x_wr_en;
    logic [IDX_W-1:0]  x_wr_addr;
    logic              x_wr_bank;

    modport master (
        input  start, max_iter,
        output busy, done, iter_cnt, y_addr, v_addr, v_bank, mult_valid,
               acc_en, acc_first, diag_cap, sub_valid, div_valid,
               x_wr_en, x_wr_addr, x_wr_bank
    );

    modport slave (
        output start, max_iter,
        input  busy, done, iter_cnt, y_addr, v_addr, v_bank, mult_valid,
               acc_en, acc_first, diag_cap, sub_valid, div_valid,
               x_wr_en, x_wr_addr, x_wr_bank
    );
endinterface

// File: rtl/jacobi_row_sequencer.sv
// Sequences one Jacobi row at a time: column issues, accumulate/diag capture,
// subtract, divide and x write-back, sweeping rows and ping-ponging x banks.
module jacobi_row_sequencer #(
    parameter int unsigned DIM      = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned MULT_LAT = 3,
    parameter int unsigned ADD_LAT  = 2,
    parameter int unsigned DIV_LAT  = 6
) (
    input logic                     clock,
    input logic                     reset,
    jacobi_row_sequencer_if.master  bus
);
    localparam int unsigned DRAIN_LEN = MULT_LAT + ADD_LAT;
    localparam int unsigned CNT_MAX   = (DRAIN_LEN > DIV_LAT) ? DRAIN_LEN : DIV_LAT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned GAP_W     = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_DRAIN, S_SUB, S_DIV, S_WRITE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_col;
    logic [GAP_W-1:0]   r_gap;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_iter;
    logic [7:0]         r_max_iter;
    logic               r_v_bank;
    logic               r_x_wr_bank;
    logic               r_busy;
    logic               r_done;
    logic [ADDR_W-1:0]  r_y_addr;
    logic [IDX_W-1:0]   r_v_addr;
    logic               r_mult_valid;
    logic               r_acc_en;
    logic               r_acc_first;
    logic               r_diag_cap;
    logic               r_sub_valid;
    logic               r_div_valid;
    logic               r_x_wr_en;
    logic [IDX_W-1:0]   r_x_wr_addr;
    logic [MULT_LAT-1:0] r_pipe_v;
    logic [MULT_LAT-1:0] r_pipe_d;
    logic [MULT_LAT-1:0] r_pipe_f;

    logic               w_issue;
    logic [IDX_W-1:0]   w_row;
    logic [IDX_W-1:0]   w_col;
    logic               w_diag;
    logic               w_first;
    logic               w_last_iter;

    // Next-cycle issue decision; the row/col chosen here also become the new r_row/r_col.
    always_comb begin
        w_issue     = 1'b0;
        w_row       = r_row;
        w_col       = r_col;
        w_last_iter = (r_iter == 8'(r_max_iter - 8'd1));
        case (r_state)
            S_IDLE: begin
                if (bus.start && (bus.max_iter != 8'd0)) begin
                    w_issue = 1'b1;
                    w_row   = '0;
                    w_col   = '0;
                end
            end
            S_ISSUE: begin
                if ((r_gap == GAP_W'(ADD_LAT - 1)) && (r_col != LAST_IDX)) begin
                    w_issue = 1'b1;
                    w_col   = r_col + 1'b1;
                end
            end
            S_WRITE: begin
                if (r_row != LAST_IDX) begin
                    w_issue = 1'b1;
                    w_row   = r_row + 1'b1;
                    w_col   = '0;
                end else if (!w_last_iter) begin
                    w_issue = 1'b1;
                    w_row   = '0;
                    w_col   = '0;
                end
            end
            default: ;
        endcase
        w_diag  = (w_col == w_row);
        w_first = (w_row == '0) ? (w_col == IDX_W'(1)) : (w_col == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_gap        <= '0;
            r_cnt        <= '0;
            r_iter       <= '0;
            r_max_iter   <= '0;
            r_v_bank     <= 1'b0;
            r_x_wr_bank  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_y_addr     <= '0;
            r_v_addr     <= '0;
            r_mult_valid <= 1'b0;
            r_acc_en     <= 1'b0;
            r_acc_first  <= 1'b0;
            r_diag_cap   <= 1'b0;
            r_sub_valid  <= 1'b0;
            r_div_valid  <= 1'b0;
            r_x_wr_en    <= 1'b0;
            r_x_wr_addr  <= '0;
            r_pipe_v     <= '0;
            r_pipe_d     <= '0;
            r_pipe_f     <= '0;
        end else begin
            r_mult_valid <= w_issue;
            r_done       <= 1'b0;
            r_sub_valid  <= 1'b0;
            r_div_valid  <= 1'b0;
            r_x_wr_en    <= 1'b0;

            // Product slot tracking: the tail stage lands exactly MULT_LAT cycles after issue.
            r_acc_en    <= r_pipe_v[MULT_LAT-1] & ~r_pipe_d[MULT_LAT-1];
            r_acc_first <= r_pipe_v[MULT_LAT-1] & ~r_pipe_d[MULT_LAT-1] & r_pipe_f[MULT_LAT-1];
            r_diag_cap  <= r_pipe_v[MULT_LAT-1] &  r_pipe_d[MULT_LAT-1];
            for (int i = MULT_LAT - 1; i > 0; i--) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_d[i] <= r_pipe_d[i-1];
                r_pipe_f[i] <= r_pipe_f[i-1];
            end
            r_pipe_v[0] <= w_issue;
            r_pipe_d[0] <= w_issue & w_diag;
            r_pipe_f[0] <= w_issue & w_first;

            // Addresses walk linearly through Y, so each issue is the previous +1 except at (0,0).
            if (w_issue) begin
                r_row    <= w_row;
                r_col    <= w_col;
                r_v_addr <= w_col;
                r_gap    <= '0;
                r_y_addr <= ((w_row == '0) && (w_col == '0)) ? '0 : r_y_addr + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.max_iter != 8'd0) begin
                            r_state    <= S_ISSUE;
                            r_iter     <= '0;
                            r_max_iter <= bus.max_iter;
                            r_busy     <= 1'b1;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_gap == GAP_W'(ADD_LAT - 1)) begin
                        if (r_col == LAST_IDX) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(DRAIN_LEN - 1)) begin
                        r_state     <= S_SUB;
                        r_cnt       <= '0;
                        r_sub_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SUB: begin
                    if (r_cnt == CNT_W'(ADD_LAT - 1)) begin
                        r_state     <= S_DIV;
                        r_cnt       <= '0;
                        r_div_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == CNT_W'(DIV_LAT - 1)) begin
                        r_state     <= S_WRITE;
                        r_cnt       <= '0;
                        r_x_wr_en   <= 1'b1;
                        r_x_wr_addr <= r_row;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_row != LAST_IDX) begin
                        r_state <= S_ISSUE;
                    end else if (!w_last_iter) begin
                        r_state     <= S_ISSUE;
                        r_iter      <= r_iter + 8'd1;
                        r_v_bank    <= ~r_v_bank;
                        r_x_wr_bank <= r_v_bank;
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.iter_cnt   = r_iter;
    assign bus.y_addr     = r_y_addr;
    assign bus.v_addr     = r_v_addr;
    assign bus.v_bank     = r_v_bank;
    assign bus.mult_valid = r_mult_valid;
    assign bus.acc_en     = r_acc_en;
    assign bus.acc_first  = r_acc_first;
    assign bus.diag_cap   = r_diag_cap;
    assign bus.sub_valid  = r_sub_valid;
    assign bus.div_valid  = r_div_valid;
    assign bus.x_wr_en    = r_x_wr_en;
    assign bus.x_wr_addr  = r_x_wr_addr;
    assign bus.x_wr_bank  = r_x_wr_bank;
endmodule

// File: tb/tb_jacobi_row_sequencer.sv
// Directed bench for jacobi_row_sequencer at default parameters (DIM=4, 22-cycle rows).
module tb_jacobi_row_sequencer;
    localparam int ROW_PERIOD = 22;
    localparam int NDIM       = 4;

    typedef logic [42:0] vec_t;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    jacobi_row_sequencer_if #(.ADDR_W(12), .IDX_W(6)) bus ();

    jacobi_row_sequencer #(
        .DIM(4), .ADDR_W(12), .IDX_W(6), .MULT_LAT(3), .ADD_LAT(2), .DIV_LAT(6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs c cycles after start (cycle 0 = start high); addresses zero where not strobed.
    function automatic vec_t exp_vec(input int c, input int mi);
        int total, slot, k, row, it, col, pc;
        logic bsy, dn, mv, acc, fst, dg, sb, dv, wr, bank;
        logic [7:0]  iter;
        logic [11:0] ya;
        logic [5:0]  va, xa;
        total = ROW_PERIOD * NDIM * mi;
        bsy = 0; dn = 0; mv = 0; acc = 0; fst = 0; dg = 0; sb = 0; dv = 0; wr = 0; bank = 0;
        iter = 8'd0; ya = 12'd0; va = 6'd0; xa = 6'd0;
        if (mi == 0) begin
            dn = (c == 1);
        end else if (c >= 1 && c <= total) begin
            slot = (c - 1) / ROW_PERIOD;
            k    = (c - 1) % ROW_PERIOD;
            row  = slot % NDIM;
            it   = slot / NDIM;
            bsy  = 1;
            iter = 8'(it);
            bank = ((it % 2) == 1);
            if (k < 8 && (k % 2) == 0) begin
                mv  = 1;
                col = k / 2;
                ya  = 12'(row * NDIM + col);
                va  = 6'(col);
            end
            if (k >= 3 && k <= 9 && (k % 2) == 1) begin
                pc = (k - 3) / 2;
                if (pc == row) dg = 1;
                else begin
                    acc = 1;
                    fst = (pc == ((row == 0) ? 1 : 0));
                end
            end
            sb = (k == 13);
            dv = (k == 15);
            if (k == 21) begin
                wr = 1;
                xa = 6'(row);
            end
        end else if (c > total) begin
            dn   = (c == total + 1);
            iter = 8'(mi - 1);
            bank = (((mi - 1) % 2) == 1);
        end
        return {bsy, dn, mv, acc, fst, dg, sb, dv, wr, bank, ~bank, iter, ya, va, xa};
    endfunction

    function automatic vec_t obs_vec(input logic keep_y, input logic keep_x);
        return {bus.busy, bus.done, bus.mult_valid, bus.acc_en, bus.acc_first, bus.diag_cap,
                bus.sub_valid, bus.div_valid, bus.x_wr_en, bus.v_bank, bus.x_wr_bank,
                bus.iter_cnt,
                keep_y ? bus.y_addr : 12'd0, keep_y ? bus.v_addr : 6'd0,
                keep_x ? bus.x_wr_addr : 6'd0};
    endfunction

    function automatic vec_t rst_vec();
        vec_t v;
        v = '0;
        v[32] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        bus.start    = 1'b0;
        bus.max_iter = 8'd0;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        vec_t o;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.max_iter = 8'd1;
        repeat (2) @(negedge clock);
        o = obs_vec(1'b1, 1'b1);
        n_tests++;
        if (o !== rst_vec()) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", o, rst_vec());
        end
        bus.start = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        o = obs_vec(1'b1, 1'b1);
        n_tests++;
        if (o !== rst_vec()) begin
            n_fail++;
            $display("FAIL reset_release_idle got=%h exp=%h", o, rst_vec());
        end
    endtask

    task automatic test_single_sweep();
        vec_t e, o;
        int n_mv, n_acc, n_diag, n_done;
        n_mv = 0; n_acc = 0; n_diag = 0; n_done = 0;
        do_reset();
        @(negedge clock);
        bus.max_iter = 8'd1;
        bus.start    = 1'b1;
        for (int c = 1; c <= 92; c++) begin
            @(negedge clock);
            e = exp_vec(c, 1);
            o = obs_vec(e[40], e[34]);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single_sweep c=%0d got=%h exp=%h", c, o, e);
            end
            n_mv   += int'(bus.mult_valid);
            n_acc  += int'(bus.acc_en);
            n_diag += int'(bus.diag_cap);
            n_done += int'(bus.done);
            if (c == 1) bus.start = 1'b0;
        end
        n_tests++;
        if (n_mv != 16 || n_acc != 12 || n_diag != 4 || n_done != 1) begin
            n_fail++;
            $display("FAIL single_sweep_counts got mv=%0d acc=%0d diag=%0d done=%0d exp 16 12 4 1",
                     n_mv, n_acc, n_diag, n_done);
        end
    endtask

    task automatic test_two_sweeps();
        vec_t e, o;
        int n_done;
        logic saw_bank1;
        n_done = 0; saw_bank1 = 1'b0;
        do_reset();
        @(negedge clock);
        bus.max_iter = 8'd2;
        bus.start    = 1'b1;
        for (int c = 1; c <= 180; c++) begin
            @(negedge clock);
            e = exp_vec(c, 2);
            o = obs_vec(e[40], e[34]);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL two_sweeps c=%0d got=%h exp=%h", c, o, e);
            end
            n_done += int'(bus.done);
            if (c == 100 && bus.v_bank === 1'b1 && bus.iter_cnt === 8'd1) saw_bank1 = 1'b1;
            if (c == 1) bus.start = 1'b0;
        end
        n_tests++;
        if (n_done != 1 || !saw_bank1) begin
            n_fail++;
            $display("FAIL two_sweeps_bank got done=%0d bank1=%0b exp done=1 bank1=1", n_done, saw_bank1);
        end
    endtask

    task automatic test_zero_iter();
        vec_t e, o;
        int n_busy, n_mv;
        n_busy = 0; n_mv = 0;
        do_reset();
        @(negedge clock);
        bus.max_iter = 8'd0;
        bus.start    = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            e = exp_vec(c, 0);
            o = obs_vec(1'b1, 1'b1);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL zero_iter c=%0d got=%h exp=%h", c, o, e);
            end
            n_busy += int'(bus.busy);
            n_mv   += int'(bus.mult_valid);
            if (c == 1) bus.start = 1'b0;
        end
        n_tests++;
        if (n_busy != 0 || n_mv != 0) begin
            n_fail++;
            $display("FAIL zero_iter_quiet got busy=%0d mv=%0d exp 0 0", n_busy, n_mv);
        end
    endtask

    task automatic test_start_while_busy();
        vec_t e, o;
        do_reset();
        @(negedge clock);
        bus.max_iter = 8'd1;
        bus.start    = 1'b1;
        for (int c = 1; c <= 92; c++) begin
            @(negedge clock);
            e = exp_vec(c, 1);
            o = obs_vec(e[40], e[34]);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL start_while_busy c=%0d got=%h exp=%h", c, o, e);
            end
            if (c == 1) bus.start = 1'b0;
            if (c == 50) begin
                bus.start    = 1'b1;
                bus.max_iter = 8'd3;
            end
            if (c == 51) begin
                bus.start    = 1'b0;
                bus.max_iter = 8'd1;
            end
        end
    endtask

    task automatic test_reset_mid_solve();
        vec_t e, o;
        do_reset();
        @(negedge clock);
        bus.max_iter = 8'd1;
        bus.start    = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            @(negedge clock);
            e = exp_vec(c, 1);
            o = obs_vec(e[40], e[34]);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_pre c=%0d got=%h exp=%h", c, o, e);
            end
            if (c == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        for (int c = 40; c <= 46; c++) begin
            @(negedge clock);
            o = obs_vec(1'b1, 1'b1);
            n_tests++;
            if (o !== rst_vec()) begin
                n_fail++;
                $display("FAIL reset_mid_abort c=%0d got=%h exp=%h", c, o, rst_vec());
            end
            if (c == 40) reset = 1'b0;
        end
        bus.start = 1'b1;
        for (int c = 1; c <= 92; c++) begin
            @(negedge clock);
            e = exp_vec(c, 1);
            o = obs_vec(e[40], e[34]);
            n_tests++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_restart c=%0d got=%h exp=%h", c, o, e);
            end
            if (c == 1) bus.start = 1'b0;
        end
    endtask

    task automatic test_row2_diag();
        int n_acc, n_diag, diag_c, first_c, n_overlap;
        n_acc = 0; n_diag = 0; diag_c = -1; first_c = -1; n_overlap = 0;
        do_reset();
        @(negedge clock);
        bus.max_iter = 8'd1;
        bus.start    = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clock);
            if (c == 1) bus.start = 1'b0;
            if (bus.acc_en === 1'b1 && bus.diag_cap === 1'b1) n_overlap++;
            if (c >= 45 && c <= 66) begin
                if (bus.acc_en === 1'b1) n_acc++;
                if (bus.diag_cap === 1'b1) begin
                    n_diag++;
                    diag_c = c;
                end
                if (bus.acc_first === 1'b1) first_c = c;
            end
        end
        n_tests++;
        if (n_acc != 3 || n_diag != 1 || diag_c != 52 || first_c != 48 || n_overlap != 0) begin
            n_fail++;
            $display("FAIL row2_diag got acc=%0d diag=%0d diag_c=%0d first_c=%0d overlap=%0d exp 3 1 52 48 0",
                     n_acc, n_diag, diag_c, first_c, n_overlap);
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.max_iter = 8'd0;
        test_reset();
        test_single_sweep();
        test_two_sweeps();
        test_zero_iter();
        test_start_while_busy();
        test_reset_mid_solve();
        test_row2_diag();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
